aes_din_pack: RTL and testbench



---
 rtl/aes_pkg.sv | 14 +
 rtl/aes_blk_fifo.sv | 52 +++++
 rtl/aes_din_pack.sv | 86 ++++++++
 tb/tb_aes_din_pack.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES datapath constants and the 128-bit block type.
package aes_pkg;

    localparam int AES_BLOCK_W       = 128;
    localparam int AES_WORD_W        = 32;
    localparam int AES_WORDS_PER_BLK = 4;

    typedef logic [AES_BLOCK_W-1:0] aes_blk_t;

    function automatic logic [AES_WORD_W-1:0] byte_rev(input logic [AES_WORD_W-1:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_blk_fifo.sv
// Block FIFO between the word packer and the AES core; push/pop are
// pre-qualified by the caller, clear is a synchronous flush.
module aes_blk_fifo
    import aes_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  aes_blk_t                 push_data,
    input  logic                     pop,
    output aes_blk_t                 head,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    aes_blk_t        mem [DEPTH];
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;

    assign head = mem[rptr];

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else if (clear) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/aes_din_pack.sv
// Packs a 32-bit word stream into 128-bit blocks and paces them into the AES core.
// Build option: AES_DIN_BYTE_SWAP_EN byte-reverses each word before packing.
module aes_din_pack
    import aes_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_enable,
    input  logic                          i_clear,
    input  logic [AES_WORD_W-1:0]         i_word,
    input  logic                          i_word_valid,
    output logic                          o_word_ready,
    input  logic                          i_core_ready,
    input  logic                          i_key_ready,
    output aes_blk_t                      o_data,
    output logic                          o_data_valid,
    output logic [$clog2(FIFO_DEPTH):0]   o_level
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

    logic [1:0]              wcnt;
    logic [AES_WORD_W*3-1:0] pack;
    logic [AES_WORD_W-1:0]   word_in;
    logic [LW-1:0]           level;
    logic                    issued_q;
    logic                    accept;
    logic                    push;
    logic                    issue;
    aes_blk_t                head;

`ifdef AES_DIN_BYTE_SWAP_EN
    assign word_in = byte_rev(i_word);
`else
    assign word_in = i_word;
`endif

    // Core ready lags one cycle, so the previous pulse blocks the next issue.
    assign issued_q     = o_data_valid;
    assign o_level      = level;
    assign o_word_ready = !i_clear && (wcnt != 2'd3 || level < DEPTH_L);
    assign accept       = i_enable && i_word_valid && o_word_ready;
    assign push         = accept && (wcnt == 2'd3);
    assign issue        = i_enable && !i_clear && (level != '0) &&
                          i_core_ready && i_key_ready && !issued_q;

    aes_blk_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (i_enable && i_clear),
        .push      (push),
        .push_data ({pack, word_in}),
        .pop       (issue),
        .head      (head),
        .level     (level)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wcnt         <= '0;
            pack         <= '0;
            o_data       <= '0;
            o_data_valid <= 1'b0;
        end else if (i_enable) begin
            if (i_clear) begin
                wcnt <= '0;
            end else if (accept) begin
                case (wcnt)
                    2'd0:    pack[95:64] <= word_in;
                    2'd1:    pack[63:32] <= word_in;
                    2'd2:    pack[31:0]  <= word_in;
                    default: pack        <= pack;
                endcase
                wcnt <= wcnt + 2'd1;
            end
            o_data_valid <= issue;
            if (issue) begin
                o_data <= head;
            end
        end
    end

endmodule

// File: tb/tb_aes_din_pack.sv
// Self-checking bench for aes_din_pack: table-driven fill/drain plus scoreboarded corner sequences.
module tb_aes_din_pack;
    import aes_pkg::*;

    localparam int DEPTH = 2;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            i_enable = 1'b1;
    logic            i_clear = 1'b0;
    logic [31:0]     i_word = '0;
    logic            i_word_valid = 1'b0;
    logic            o_word_ready;
    logic            i_core_ready = 1'b0;
    logic            i_key_ready = 1'b0;
    aes_blk_t        o_data;
    logic            o_data_valid;
    logic [LW-1:0]   o_level;

    aes_din_pack #(.FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_enable     (i_enable),
        .i_clear      (i_clear),
        .i_word       (i_word),
        .i_word_valid (i_word_valid),
        .o_word_ready (o_word_ready),
        .i_core_ready (i_core_ready),
        .i_key_ready  (i_key_ready),
        .o_data       (o_data),
        .o_data_valid (o_data_valid),
        .o_level      (o_level)
    );

    always #5 clk = ~clk;

    int       total = 0;
    int       bad = 0;
    int       n_issued = 0;
    aes_blk_t exp_q[$];
    aes_blk_t m_blk = '0;
    int       m_wcnt = 0;
    logic     prev_v = 1'b0, prev_core = 1'b0, prev_key = 1'b0, prev_en = 1'b0;

    function automatic logic [31:0] sw(input logic [31:0] w);
`ifdef AES_DIN_BYTE_SWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic model_accept(input logic [31:0] w);
        m_blk[127-32*m_wcnt -: 32] = sw(w);
        if (m_wcnt == 3) begin
            exp_q.push_back(m_blk);
            m_wcnt = 0;
        end else begin
            m_wcnt++;
        end
    endtask

    // Starts and ends at posedge+1; acceptance judged from the handshake seen mid-cycle.
    task automatic step(input logic v, input logic [31:0] w, output logic acc);
        i_word_valid = v;
        i_word       = w;
        @(negedge clk);
        acc = i_enable && v && o_word_ready && !reset;
        @(posedge clk);
        if (acc) model_accept(w);
        if (i_clear && i_enable) begin
            exp_q.delete();
            m_wcnt = 0;
        end
        #1;
        i_word_valid = 1'b0;
    endtask

    task automatic push_words(input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3, input int n);
        logic [31:0] ws [4];
        logic acc;
        int k;
        int budget;
        ws[0] = w0; ws[1] = w1; ws[2] = w2; ws[3] = w3;
        k = 0;
        budget = 0;
        while (k < n && budget < 50) begin
            step(1'b1, ws[k], acc);
            if (acc) k++;
            budget++;
        end
        check("push_budget", 128'(k), 128'(n));
    endtask

    task automatic drain(input string name, input int budget);
        logic acc;
        int c;
        c = 0;
        while ((exp_q.size() != 0 || o_data_valid) && c < budget) begin
            step(1'b0, '0, acc);
            c++;
        end
        step(1'b0, '0, acc);
        check(name, 128'(exp_q.size()), 128'd0);
    endtask

    // Scoreboard: every issue pulse pops the oldest expected block.
    always @(negedge clk) begin
        if (reset) begin
            prev_v = 1'b0;
        end else begin
            if (o_data_valid && !prev_v) begin
                n_issued++;
                check("issue_gate", {125'd0, prev_core, prev_key, prev_en}, 128'd7);
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_pulse: got %0h want none", o_data);
                end else if (o_data !== exp_q[0]) begin
                    bad++;
                    $display("FAIL block_data: got %0h want %0h", o_data, exp_q[0]);
                    void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
            end
            prev_v = o_data_valid;
        end
        prev_core = i_core_ready;
        prev_key  = i_key_ready;
        prev_en   = i_enable;
    end

    typedef struct {
        logic          v;
        logic [31:0]   w;
        logic          key;
        logic [LW-1:0] lvl;
        logic          rdy;
        logic          vld;
    } vec_t;

    vec_t tbl [18];

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        acc;
        int          n0;
        int          idx;
        int          c;
        logic [LW-1:0] lvl0;
        logic [31:0] words [24];
        aes_blk_t    exp_e;

        tbl[0]  = '{1'b1, 32'hA0000000, 1'b0, 2'd0, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 32'hA0000001, 1'b0, 2'd0, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 32'hA0000002, 1'b0, 2'd0, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 32'hA0000003, 1'b0, 2'd1, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 32'hB0000000, 1'b0, 2'd1, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 32'hB0000001, 1'b0, 2'd1, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 32'hB0000002, 1'b0, 2'd1, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 32'hB0000003, 1'b0, 2'd2, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 32'hC0000000, 1'b0, 2'd2, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 32'hC0000001, 1'b0, 2'd2, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 32'hC0000002, 1'b0, 2'd2, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 32'hC0000003, 1'b0, 2'd2, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 32'h00000000, 1'b1, 2'd1, 1'b1, 1'b1};
        tbl[13] = '{1'b0, 32'h00000000, 1'b1, 2'd1, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 32'h00000000, 1'b1, 2'd0, 1'b1, 1'b1};
        tbl[15] = '{1'b1, 32'hC0000003, 1'b1, 2'd1, 1'b1, 1'b0};
        tbl[16] = '{1'b0, 32'h00000000, 1'b1, 2'd0, 1'b1, 1'b1};
        tbl[17] = '{1'b0, 32'h00000000, 1'b1, 2'd0, 1'b1, 1'b0};

        // Reset values
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_level", 128'(o_level), 128'd0);
        check("rst_valid", 128'(o_data_valid), 128'd0);
        check("rst_data", o_data, 128'd0);
        check("rst_ready", 128'(o_word_ready), 128'd1);

        // Single block, latency and content
        i_core_ready = 1'b1;
        i_key_ready  = 1'b1;
        push_words(32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF, 4);
        check("lat_level_n1", 128'(o_level), 128'd1);
        check("lat_valid_n1", 128'(o_data_valid), 128'd0);
        step(1'b0, '0, acc);
        check("lat_valid_n2", 128'(o_data_valid), 128'd1);
`ifdef AES_DIN_BYTE_SWAP_EN
        check("lat_data", o_data, 128'h33221100_77665544_BBAA9988_FFEEDDCC);
`else
        check("lat_data", o_data, 128'h00112233_44556677_8899AABB_CCDDEEFF);
`endif
        step(1'b0, '0, acc);
        check("lat_valid_n3", 128'(o_data_valid), 128'd0);

        // Key-ready hold-off, full FIFO, then paced drain
        i_key_ready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            i_key_ready = tbl[i].key;
            step(tbl[i].v, tbl[i].w, acc);
            check($sformatf("tbl%0d_level", i), 128'(o_level), 128'(tbl[i].lvl));
            check($sformatf("tbl%0d_ready", i), 128'(o_word_ready), 128'(tbl[i].rdy));
            check($sformatf("tbl%0d_valid", i), 128'(o_data_valid), 128'(tbl[i].vld));
        end
        check("tbl_drained", 128'(exp_q.size()), 128'd0);

        // Core ready toggling every 3 cycles under a continuous stream
        for (int i = 0; i < 24; i++) words[i] = $urandom;
        n0  = n_issued;
        idx = 0;
        c   = 0;
        while (!(idx == 24 && exp_q.size() == 0) && c < 400) begin
            i_core_ready = ((c / 3) % 2) == 1;
            step(idx < 24, (idx < 24) ? words[idx] : 32'd0, acc);
            if (acc) idx++;
            c++;
        end
        i_core_ready = 1'b1;
        drain("toggle_drained", 20);
        check("toggle_count", 128'(n_issued - n0), 128'd6);

        // Clear drops the partial block, the buffered block and a coincident word
        i_core_ready = 1'b0;
        push_words(32'hD0000000, 32'hD0000001, 32'hD0000002, 32'hD0000003, 4);
        push_words(32'hD1000000, 32'hD1000001, 32'h0, 32'h0, 2);
        check("clr_level_before", 128'(o_level), 128'd1);
        i_clear = 1'b1;
        #1;
        check("clr_ready_low", 128'(o_word_ready), 128'd0);
        step(1'b1, 32'hDEADBEEF, acc);
        i_clear = 1'b0;
        #1;
        check("clr_level", 128'(o_level), 128'd0);
        check("clr_ready", 128'(o_word_ready), 128'd1);
        i_core_ready = 1'b1;
        push_words(32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10, 4);
        exp_e = {sw(32'h01020304), sw(32'h05060708), sw(32'h090A0B0C), sw(32'h0D0E0F10)};
        drain("clr_drained", 20);
        check("clr_fresh_block", o_data, exp_e);

        // Asynchronous reset mid-block with one block buffered
        i_key_ready = 1'b0;
        push_words(32'hE0000000, 32'hE0000001, 32'hE0000002, 32'hE0000003, 4);
        push_words(32'hE1000000, 32'hE1000001, 32'h0, 32'h0, 2);
        check("ares_level_before", 128'(o_level), 128'd1);
        #2 reset = 1'b1;
        #1;
        check("ares_level", 128'(o_level), 128'd0);
        check("ares_valid", 128'(o_data_valid), 128'd0);
        check("ares_data", o_data, 128'd0);
        check("ares_ready", 128'(o_word_ready), 128'd1);
        exp_q.delete();
        m_wcnt = 0;
        @(posedge clk);
        #1 reset = 1'b0;
        i_key_ready = 1'b1;
        n0 = n_issued;
        repeat (8) step(1'b0, '0, acc);
        check("ares_no_stale", 128'(n_issued - n0), 128'd0);
        check("ares_level_after", 128'(o_level), 128'd0);

        // Enable low for 5 cycles mid-stream
        for (int i = 0; i < 12; i++) words[i] = 32'hF0000000 + 32'(i);
        n0   = n_issued;
        idx  = 0;
        c    = 0;
        lvl0 = '0;
        while (idx < 12 && c < 200) begin
            i_enable = !(c >= 5 && c < 10);
            if (c == 5) lvl0 = o_level;
            step(1'b1, words[idx], acc);
            if (acc) idx++;
            if (c >= 5 && c < 10) begin
                check($sformatf("en_hold_level%0d", c), 128'(o_level), 128'(lvl0));
                check($sformatf("en_no_accept%0d", c), 128'(acc), 128'd0);
            end
            c++;
        end
        i_enable = 1'b1;
        drain("en_drained", 20);
        check("en_count", 128'(n_issued - n0), 128'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
